line_width_converter: RTL and testbench
=======================================

Name: line_width_converter

Overview:
Single-clock, parametrised line buffer and width converter for the YUV pixel path. It sits after the rgb2yuv stage, inside the MIPI byte-clock domain.
- Wide input pixel words (PIXEL_PER_CLK pixels, 16 bit/pixel) are captured into ping-pong line banks.
- Each committed line is replayed as narrow OUT_PIXELS-wide beats over a valid/ready handshake with end-of-line marking.
- Adds backpressure, overflow/truncation detection and zero-length-line filtering.

Parameters:
- PIXEL_PER_CLK, 8, input pixels per word; one of 1,2,4,8; IN_W = PIXEL_PER_CLK*16.
- OUT_PIXELS, 2, output pixels per beat; one of 1,2,4; OUT_W = OUT_PIXELS*16.
  - Must satisfy PIXEL_PER_CLK >= OUT_PIXELS. RATIO = PIXEL_PER_CLK/OUT_PIXELS.
- LINE_WORDS_MAX, 1024, input words per bank, power of 2. AW = log2(LINE_WORDS_MAX).

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- frame_sync_i  in  1  active-high synchronous flush, level.
- line_sync_i  in  1  active high; rising edge commits current line.
- data_i  in  IN_W  input pixel word.
- data_in_valid_i  in  1  write strobe for data_i.
- output_o  out  OUT_W  output beat.
- output_valid_o  out  1  beat valid.
- output_ready_i  in  1  sink accepts beat.
- output_last_o  out  1  last beat of line, qualified by output_valid_o.
- overflow_o  out  1  one-cycle pulse: line dropped.
- truncated_o  out  1  one-cycle pulse: line exceeded LINE_WORDS_MAX.

Behaviour:
- Reset (rst_n_i low):
  - Outputs: output_o=0, output_valid_o=0, output_last_o=0, overflow_o=0, truncated_o=0.
  - State: both banks empty, wr_bank=0, rd_bank=0, write pointer=0, read FSM IDLE, last_line_sync=0.
- frame_sync_i high at a clock edge: same state as reset, applied synchronously. Output drops the cycle after. RAM contents are don't-care.
- Line-sync edge: detected when line_sync_i=1 and registered last_line_sync=0.
- Write side:
  - data_in_valid_i=1 with a free write bank and wptr<LINE_WORDS_MAX: write data_i to bank[wr_bank][wptr]; wptr+1.
  - wptr==LINE_WORDS_MAX: word dropped; the line is marked truncated.
  - On line-sync edge with wptr>0: len[wr_bank]=wptr; full[wr_bank]=1; wr_bank toggles; wptr=0; truncated_o pulses if the line was marked truncated.
  - On line-sync edge with wptr==0: no commit, no toggle (zero-length line ignored).
  - Edge and data_in_valid_i in the same cycle: commit first. The word goes to the new bank at address 0 if that bank is free.
  - If the new wr_bank is still full (being read): the line is dropped. All writes are suppressed until the next edge, and overflow_o pulses at that next edge. No commit of the dropped line.
- Read FSM:
  - IDLE: full[rd_bank]=1 -> LOAD.
  - LOAD: issue RAM read at rptr (1-cycle read latency) -> WAIT.
  - WAIT: capture word into shift register; beat=0; -> SEND.
  - SEND: output_valid_o=1; output_o = word[beat*OUT_W +: OUT_W], lowest pixels first.
    - On output_valid_o && output_ready_i: beat+1.
    - After beat RATIO-1: rptr+1 and -> LOAD, or the line ends.
- While output_valid_o=1 and output_ready_i=0: output_o and output_last_o are held stable.
- output_last_o=1 on beat RATIO-1 of word len-1.
- Line end: when that beat is accepted, full[rd_bank]=0, rd_bank toggles, rptr=0, -> IDLE.
- Latency: first output_valid_o rises on the 4th rising edge after the edge that sampled the line-sync edge, with the sink ready.
- Throughput with RATIO=1: one beat per 3 cycles; the LOAD/WAIT bubble is permitted.
- Pointer widths: wptr is AW+1 bits; rptr is AW bits; len is AW+1 bits.

Optional Feature:
LWC_DROP_COUNTERS_EN
- Defined: adds outputs dropped_lines_o[15:0] and truncated_lines_o[15:0].
  - Each increments on its corresponding pulse and saturates at 16'hFFFF.
  - Cleared by reset and frame_sync_i.
- Undefined: ports absent; pulses only.

Test Plan:
- PIXEL_PER_CLK=8, OUT_PIXELS=2, LINE_WORDS_MAX=16, ready=1. Write 3 words (pixel n value = n), then a line-sync edge.
  -> 12 beats, pixels {0,1},{2,3}…{22,23}. output_last_o only on beat 12. First valid 4 cycles after the edge.
- Same line with output_ready_i toggling 1,0 each cycle.
  -> output_o stable in every unaccepted cycle. All 12 beats in order, no loss or duplication.
- Line-sync edge with no data.
  -> no output, no pulses, wr_bank unchanged.
- ready=0. Commit lines A (2 words) and B (2 words), then write line C and raise line-sync.
  -> overflow_o pulses once at C's edge. After release, A then B are emitted; C never appears.
- 20 words into LINE_WORDS_MAX=16, then an edge.
  -> truncated_o pulse; exactly 16 words × 4 beats output.
- frame_sync_i high mid-SEND.
  -> output_valid_o=0 next cycle. Both banks empty. A subsequent line is output correctly from bank 0.

Source files
------------

// File: rtl/line_width_converter_if.sv
// Pixel-path bus for line_width_converter: write side, beat stream and drop/truncate pulses.
// LWC_DROP_COUNTERS_EN adds the saturating drop/truncate counters.
interface line_width_converter_if #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32
);
    logic             frame_sync_i;
    logic             line_sync_i;
    logic [IN_W-1:0]  data_i;
    logic             data_in_valid_i;
    logic [OUT_W-1:0] output_o;
    logic             output_valid_o;
    logic             output_ready_i;
    logic             output_last_o;
    logic             overflow_o;
    logic             truncated_o;
`ifdef LWC_DROP_COUNTERS_EN
    logic [15:0]      dropped_lines_o;
    logic [15:0]      truncated_lines_o;
`endif

    modport slave (
        input  frame_sync_i, line_sync_i, data_i, data_in_valid_i, output_ready_i,
`ifdef LWC_DROP_COUNTERS_EN
        output dropped_lines_o, truncated_lines_o,
`endif
        output output_o, output_valid_o, output_last_o, overflow_o, truncated_o
    );

    modport master (
        output frame_sync_i, line_sync_i, data_i, data_in_valid_i, output_ready_i,
`ifdef LWC_DROP_COUNTERS_EN
        input  dropped_lines_o, truncated_lines_o,
`endif
        input  output_o, output_valid_o, output_last_o, overflow_o, truncated_o
    );
endinterface

// File: rtl/line_width_converter.sv
// Ping-pong line buffer: wide pixel words in, OUT_PIXELS-wide beats out with end-of-line mark.
// Optional LWC_DROP_COUNTERS_EN adds saturating dropped/truncated line counters.
module line_width_converter #(
    parameter int PIXEL_PER_CLK  = 8,
    parameter int OUT_PIXELS     = 2,
    parameter int LINE_WORDS_MAX = 1024
) (
    input logic                   clk_i,
    input logic                   rst_n_i,
    line_width_converter_if.slave bus
);
    localparam int IN_W  = PIXEL_PER_CLK * 16;
    localparam int OUT_W = OUT_PIXELS * 16;
    localparam int RATIO = PIXEL_PER_CLK / OUT_PIXELS;
    localparam int AW    = $clog2(LINE_WORDS_MAX);
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [AW:0]   WMAX      = (AW+1)'(LINE_WORDS_MAX);
    localparam logic [AW:0]   WONE      = (AW+1)'(1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(RATIO - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_WAIT, RD_SEND} rd_state_e;

    // Inputs are registered once; sync edge detection runs on the registered copy.
    logic            in_vld_q, ls_q, last_ls_q;
    logic [IN_W-1:0] in_data_q;

    logic [1:0]       full_q, full_d;
    logic [1:0][AW:0] len_q, len_d;
    logic             wr_bank_q, wr_bank_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic             trunc_q, trunc_d, drop_q, drop_d;
    logic             ovf_q, ovf_d, trc_q, trc_d;
    logic             we;
    logic [AW:0]      waddr;

    rd_state_e        state_q;
    logic             rd_bank_q;
    logic [AW-1:0]    rptr_q;
    logic [BW-1:0]    beat_q;
    logic [IN_W-1:0]  shreg_q, rdata_q;
    logic [OUT_W-1:0] out_q;
    logic             vld_q, last_q;
    logic             sync_edge, word_last, beat_last, rd_done;

    logic [IN_W-1:0] mem [2*LINE_WORDS_MAX];

    assign sync_edge = ls_q & ~last_ls_q;
    assign word_last = ((AW+1)'(rptr_q) + WONE) == len_q[rd_bank_q];
    assign beat_last = beat_q == BEAT_LAST;
    assign rd_done   = (state_q == RD_SEND) && bus.output_ready_i && beat_last && word_last;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_vld_q <= 1'b0; in_data_q <= '0; ls_q <= 1'b0; last_ls_q <= 1'b0;
        end else if (bus.frame_sync_i) begin
            in_vld_q <= 1'b0; in_data_q <= '0; ls_q <= 1'b0; last_ls_q <= 1'b0;
        end else begin
            in_vld_q  <= bus.data_in_valid_i;
            in_data_q <= bus.data_i;
            ls_q      <= bus.line_sync_i;
            last_ls_q <= ls_q;
        end
    end

    always_comb begin
        full_d    = full_q & ~(rd_done ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00);
        len_d     = len_q;
        wr_bank_d = wr_bank_q;
        wptr_d    = wptr_q;
        trunc_d   = trunc_q;
        drop_d    = drop_q;
        ovf_d     = 1'b0;
        trc_d     = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        if (sync_edge) begin
            if (drop_q) begin
                ovf_d = 1'b1;
            end else if (wptr_q != '0) begin
                len_d[wr_bank_q]  = wptr_q;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                trc_d             = trunc_q;
            end
            wptr_d  = '0;
            trunc_d = 1'b0;
            drop_d  = 1'b0;
        end
        // A line is dropped as soon as it tries to write a bank the reader still holds.
        if (in_vld_q) begin
            if (drop_d || full_d[wr_bank_d]) begin
                drop_d = 1'b1;
            end else if (wptr_d == WMAX) begin
                trunc_d = 1'b1;
            end else begin
                we     = 1'b1;
                waddr  = {wr_bank_d, wptr_d[AW-1:0]};
                wptr_d = wptr_d + WONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q <= '0; len_q <= '0; wr_bank_q <= 1'b0; wptr_q <= '0;
            trunc_q <= 1'b0; drop_q <= 1'b0; ovf_q <= 1'b0; trc_q <= 1'b0;
        end else if (bus.frame_sync_i) begin
            full_q <= '0; len_q <= '0; wr_bank_q <= 1'b0; wptr_q <= '0;
            trunc_q <= 1'b0; drop_q <= 1'b0; ovf_q <= 1'b0; trc_q <= 1'b0;
        end else begin
            full_q <= full_d; len_q <= len_d; wr_bank_q <= wr_bank_d; wptr_q <= wptr_d;
            trunc_q <= trunc_d; drop_q <= drop_d; ovf_q <= ovf_d; trc_q <= trc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= in_data_q;
        if (state_q == RD_LOAD) rdata_q <= mem[{rd_bank_q, rptr_q}];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RD_IDLE; rd_bank_q <= 1'b0; rptr_q <= '0; beat_q <= '0;
            shreg_q <= '0; out_q <= '0; vld_q <= 1'b0; last_q <= 1'b0;
        end else if (bus.frame_sync_i) begin
            state_q <= RD_IDLE; rd_bank_q <= 1'b0; rptr_q <= '0; beat_q <= '0;
            shreg_q <= '0; out_q <= '0; vld_q <= 1'b0; last_q <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: if (full_q[rd_bank_q]) state_q <= RD_LOAD;
                RD_LOAD: state_q <= RD_WAIT;
                RD_WAIT: begin
                    shreg_q <= rdata_q;
                    out_q   <= rdata_q[OUT_W-1:0];
                    beat_q  <= '0;
                    vld_q   <= 1'b1;
                    last_q  <= (RATIO == 1) && word_last;
                    state_q <= RD_SEND;
                end
                RD_SEND: if (bus.output_ready_i) begin
                    if (beat_last) begin
                        vld_q  <= 1'b0;
                        last_q <= 1'b0;
                        if (word_last) begin
                            rptr_q    <= '0;
                            rd_bank_q <= ~rd_bank_q;
                            state_q   <= RD_IDLE;
                        end else begin
                            rptr_q  <= rptr_q + AW'(1);
                            state_q <= RD_LOAD;
                        end
                    end else begin
                        // Low pixels leave first: shift the word down one beat.
                        shreg_q <= shreg_q >> OUT_W;
                        out_q   <= OUT_W'(shreg_q >> OUT_W);
                        beat_q  <= beat_q + BW'(1);
                        last_q  <= ((beat_q + BW'(1)) == BEAT_LAST) && word_last;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign bus.output_o       = out_q;
    assign bus.output_valid_o = vld_q;
    assign bus.output_last_o  = last_q;
    assign bus.overflow_o     = ovf_q;
    assign bus.truncated_o    = trc_q;

`ifdef LWC_DROP_COUNTERS_EN
    logic [15:0] drop_cnt_q, trc_cnt_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= '0; trc_cnt_q <= '0;
        end else if (bus.frame_sync_i) begin
            drop_cnt_q <= '0; trc_cnt_q <= '0;
        end else begin
            if (ovf_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (trc_d && trc_cnt_q != 16'hFFFF) trc_cnt_q <= trc_cnt_q + 16'd1;
        end
    end
    assign bus.dropped_lines_o   = drop_cnt_q;
    assign bus.truncated_lines_o = trc_cnt_q;
`endif
endmodule

// File: tb/tb_line_width_converter.sv
// Randomised bench for line_width_converter (8 px in, 2 px out, 16-word banks) against a line-queue model.
module tb_line_width_converter;
    localparam int PPC = 8, OPX = 2, LWM = 16;
    localparam int IN_W = PPC*16, OUT_W = OPX*16, RATIO = PPC/OPX;

    typedef struct packed { logic [OUT_W-1:0] d; logic l; } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    line_width_converter_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    line_width_converter #(.PIXEL_PER_CLK(PPC), .OUT_PIXELS(OPX), .LINE_WORDS_MAX(LWM)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    int n_cmp = 0, n_err = 0;
    beat_t exp_q[$];
    int ovf_cnt = 0, trc_cnt = 0, ovf_base = 0, trc_base = 0;
    int beats_seen = 0, unexp = 0, rdy_mode = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [IN_W-1:0] pix_word(input int base, input int w);
        logic [IN_W-1:0] r;
        for (int p = 0; p < PPC; p++) r[p*16 +: 16] = 16'(base + w*PPC + p);
        return r;
    endfunction

    // Reference: a committed line of n words yields min(n,LWM) words, each split low-to-high into RATIO beats.
    task automatic push_exp(input logic [IN_W-1:0] words[$]);
        int m;
        logic [IN_W-1:0] tmp;
        beat_t e;
        m = (words.size() > LWM) ? LWM : words.size();
        for (int w = 0; w < m; w++) begin
            tmp = words[w];
            for (int b = 0; b < RATIO; b++) begin
                e.d = tmp[b*OUT_W +: OUT_W];
                e.l = (w == m-1) && (b == RATIO-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_line(input int n, input int base, input bit rnd, input bit gaps,
                             input bit exp_out, output int lat);
        logic [IN_W-1:0] words[$];
        for (int w = 0; w < n; w++)
            words.push_back(rnd ? {$urandom, $urandom, $urandom, $urandom} : pix_word(base, w));
        if (exp_out) push_exp(words);
        for (int w = 0; w < n; w++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.data_in_valid_i = 1'b0;
                step();
            end
            bus.data_i = words[w];
            bus.data_in_valid_i = 1'b1;
            step();
        end
        bus.data_in_valid_i = 1'b0;
        bus.data_i = '0;
        bus.line_sync_i = 1'b1;
        step();
        bus.line_sync_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (bus.output_valid_o && lat < 0) lat = k;
        end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || bus.output_valid_o) && k < budget) begin
            step();
            k++;
        end
        repeat (8) step();
        chk("drain_left", exp_q.size(), 0);
        chk("unexp_beats", unexp, 0);
    endtask

    // Beat monitor / scoreboard and pulse counters.
    initial begin
        logic prev_stall, prev_fs, prev_l;
        logic [OUT_W-1:0] prev_d;
        beat_t e;
        prev_stall = 1'b0; prev_fs = 1'b0; prev_l = 1'b0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (prev_stall && !prev_fs) begin
                    chk("hold_vld", bus.output_valid_o, 1'b1);
                    chk("hold_data", bus.output_o, prev_d);
                    chk("hold_last", bus.output_last_o, prev_l);
                end
                if (bus.output_valid_o && bus.output_ready_i) begin
                    beats_seen++;
                    if (exp_q.size() == 0) unexp++;
                    else begin
                        e = exp_q.pop_front();
                        chk("beat_data", bus.output_o, e.d);
                        chk("beat_last", bus.output_last_o, e.l);
                    end
                end
                prev_stall = bus.output_valid_o && !bus.output_ready_i;
                prev_d  = bus.output_o;
                prev_l  = bus.output_last_o;
                prev_fs = bus.frame_sync_i;
                if (bus.overflow_o)  ovf_cnt++;
                if (bus.truncated_o) trc_cnt++;
            end
        end
    end

    initial begin
        bus.output_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus.output_ready_i = 1'b1;
                1: bus.output_ready_i = ~bus.output_ready_i;
                2: bus.output_ready_i = 1'($urandom_range(0, 1));
                default: bus.output_ready_i = 1'b0;
            endcase
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, o0, t0, b0, n, k;
        rst_n = 1'b0;
        bus.frame_sync_i = 1'b0; bus.line_sync_i = 1'b0;
        bus.data_i = '0; bus.data_in_valid_i = 1'b0;
        repeat (3) step();
        chk("rst_data", bus.output_o, 0);
        chk("rst_vld", bus.output_valid_o, 0);
        chk("rst_last", bus.output_last_o, 0);
        chk("rst_ovf", bus.overflow_o, 0);
        chk("rst_trunc", bus.truncated_o, 0);
        rst_n = 1'b1;
        step();

        // Basic 3-word line, sink always ready
        rdy_mode = 0; step();
        b0 = beats_seen; o0 = ovf_cnt; t0 = trc_cnt;
        send_line(3, 0, 0, 0, 1, lat);
        chk("latency", lat, 4);
        drain(400);
        chk("t1_beats", beats_seen - b0, 12);
        chk("t1_ovf", ovf_cnt - o0, 0);
        chk("t1_trc", trc_cnt - t0, 0);

        // Same line, ready toggling
        rdy_mode = 1;
        b0 = beats_seen;
        send_line(3, 0, 0, 0, 1, lat);
        drain(400);
        chk("t2_beats", beats_seen - b0, 12);

        // Zero-length line
        rdy_mode = 0;
        b0 = beats_seen; o0 = ovf_cnt; t0 = trc_cnt;
        send_line(0, 0, 0, 0, 0, lat);
        drain(100);
        chk("t3_beats", beats_seen - b0, 0);
        chk("t3_ovf", ovf_cnt - o0, 0);
        chk("t3_trc", trc_cnt - t0, 0);

        // Overflow: A and B held by a stalled sink, C dropped
        rdy_mode = 3; step();
        o0 = ovf_cnt;
        send_line(2, 100, 0, 0, 1, lat);
        send_line(2, 200, 0, 0, 1, lat);
        send_line(2, 300, 0, 0, 0, lat);
        repeat (10) step();
        chk("t4_ovf", ovf_cnt - o0, 1);
        rdy_mode = 0;
        drain(400);

        // Truncation: 20 words into 16-word banks
        b0 = beats_seen; o0 = ovf_cnt; t0 = trc_cnt;
        send_line(20, 0, 0, 0, 1, lat);
        drain(600);
        chk("t5_trc", trc_cnt - t0, 1);
        chk("t5_ovf", ovf_cnt - o0, 0);
        chk("t5_beats", beats_seen - b0, LWM*RATIO);

        // Frame sync mid-send, then both banks must be free again
        rdy_mode = 3; step();
        send_line(3, 40, 0, 0, 1, lat);
        k = 0;
        while (!bus.output_valid_o && k < 50) begin step(); k++; end
        chk("t6_pre_vld", bus.output_valid_o, 1);
        bus.frame_sync_i = 1'b1;
        step();
        chk("t6_fs_vld", bus.output_valid_o, 0);
        chk("t6_fs_last", bus.output_last_o, 0);
        bus.frame_sync_i = 1'b0;
        exp_q.delete();
        ovf_base = ovf_cnt; trc_base = trc_cnt;
        o0 = ovf_cnt;
        send_line(2, 500, 0, 0, 1, lat);
        send_line(3, 600, 0, 0, 1, lat);
        repeat (5) step();
        chk("t6_ovf", ovf_cnt - o0, 0);
        rdy_mode = 0;
        drain(400);

        // Random single lines with random ready and input gaps
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(0, 20);
            o0 = ovf_cnt; t0 = trc_cnt;
            send_line(n, 0, 1, 1, 1, lat);
            drain(1500);
            chk("rnd_trc", trc_cnt - t0, (n > LWM) ? 1 : 0);
            chk("rnd_ovf", ovf_cnt - o0, 0);
        end

        // Random back-to-back pairs exercise ping-pong without loss
        for (int i = 0; i < 6; i++) begin
            o0 = ovf_cnt;
            send_line($urandom_range(1, 6), 0, 1, 1, 1, lat);
            send_line($urandom_range(1, 6), 0, 1, 1, 1, lat);
            drain(1500);
            chk("pair_ovf", ovf_cnt - o0, 0);
        end

`ifdef LWC_DROP_COUNTERS_EN
        chk("drop_cnt", bus.dropped_lines_o, ovf_cnt - ovf_base);
        chk("trunc_cnt", bus.truncated_lines_o, trc_cnt - trc_base);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
